// File: rtl/toll_reader_arbiter_pkg.sv
// Shared types and constants for the toll reader arbiter: FSM states,
// response status codes and the default lane count.
package toll_pkg;

  localparam int DEFAULT_NUM_LANES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_NO_TAG  = 2'b01;
  localparam logic [1:0] ST_REJECT  = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  // A missing tag outranks the validity fields, which are meaningless without one.
  function automatic logic [1:0] decode_status(input logic present,
                                               input logic valid,
                                               input logic sufficient);
    if (!present) begin
      return ST_NO_TAG;
    end
    return (valid && sufficient) ? ST_OK : ST_REJECT;
  endfunction

endpackage

// File: rtl/toll_reader_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting lane at or after ptr_i,
// searching upward with wrap-around. Returns the winner one-hot and as an index.
module rr_pick
  import toll_pkg::*;
#(
  parameter int NUM_LANES = DEFAULT_NUM_LANES,
  parameter int LANE_W    = 2
) (
  input  logic [NUM_LANES-1:0] req_i,
  input  logic [LANE_W-1:0]    ptr_i,
  output logic [NUM_LANES-1:0] grant_o,
  output logic [LANE_W-1:0]    idx_o,
  output logic                 any_o
);

  logic found;
  int   cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      cand = (int'(ptr_i) + i) % NUM_LANES;
      if (!found && req_i[LANE_W'(cand)]) begin
        found                    = 1'b1;
        grant_o[LANE_W'(cand)]   = 1'b1;
        idx_o                    = LANE_W'(cand);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/toll_reader_arbiter.sv
// Round-robin arbiter sharing one RFID reader among toll lanes.
// Optional reader timeout and saturating timeout counter: define READER_TIMEOUT_EN.
//
// Handshakes: a lane's lane_req is sampled only in IDLE; once granted the
// transaction always completes. lane_resp_valid[w] stays high with resp_status
// stable until lane_ack[w] is seen on a rising edge; acks from other lanes are ignored.
module toll_reader_arbiter
  import toll_pkg::*;
#(
  parameter int NUM_LANES      = DEFAULT_NUM_LANES,
  parameter int LANE_W         = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 maintenance_mode,
  input  logic [NUM_LANES-1:0] lane_req,
  input  logic [NUM_LANES-1:0] lane_ack,
  output logic [NUM_LANES-1:0] lane_grant,
  output logic [NUM_LANES-1:0] lane_resp_valid,
  output logic [1:0]           resp_status,
  output logic                 rd_start,
  output logic [LANE_W-1:0]    rd_lane,
  input  logic                 rd_done,
  input  logic                 rd_present,
  input  logic                 rd_valid,
  input  logic                 rd_sufficient,
  output logic                 busy,
  output logic [7:0]           timeout_count,
  output state_e               dbg_state
);

  state_e               state_q, state_d;
  logic [LANE_W-1:0]    w_q, w_d;
  logic [LANE_W-1:0]    ptr_q, ptr_d;
  logic [1:0]           status_q, status_d;
  logic [NUM_LANES-1:0] grant_q, grant_d;
  logic [NUM_LANES-1:0] rvalid_q, rvalid_d;
  logic                 start_q, start_d;
  logic                 busy_q, busy_d;
  logic [NUM_LANES-1:0] served_oh;

  logic [NUM_LANES-1:0] pick_grant;
  logic [LANE_W-1:0]    pick_idx;
  logic                 pick_any;

`ifdef READER_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       tcount_q, tcount_d;
`else
  // TIMEOUT_CYCLES only shapes the timeout build; this empty block keeps it referenced.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_cycles_unused
  end
`endif

  rr_pick #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W)
  ) u_pick (
    .req_i   (lane_req),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    ptr_d     = ptr_q;
    status_d  = status_q;
    grant_d   = '0;
    rvalid_d  = '0;
    served_oh = '0;
    served_oh[w_q] = 1'b1;
`ifdef READER_TIMEOUT_EN
    cnt_d     = cnt_q;
    tcount_d  = tcount_q;
`endif
    case (state_q)
      IDLE: begin
        if (!maintenance_mode && pick_any) begin
          state_d = GRANT;
          w_d     = pick_idx;
          grant_d = pick_grant;
        end
      end
      GRANT: begin
        ptr_d   = (w_q == LANE_W'(NUM_LANES - 1)) ? '0 : w_q + 1'b1;
        state_d = WAIT;
        grant_d = served_oh;
`ifdef READER_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        grant_d = served_oh;
        if (rd_done) begin
          status_d = decode_status(rd_present, rd_valid, rd_sufficient);
          state_d  = RESP;
          grant_d  = '0;
          rvalid_d = served_oh;
        end
`ifdef READER_TIMEOUT_EN
        else if (cnt_q == CNT_TERM) begin
          status_d = ST_TIMEOUT;
          state_d  = RESP;
          grant_d  = '0;
          rvalid_d = served_oh;
          if (tcount_q != 8'hFF) begin
            tcount_d = tcount_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        rvalid_d = served_oh;
        if (lane_ack[w_q]) begin
          state_d  = IDLE;
          rvalid_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    start_d = (state_d == GRANT);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      w_q      <= '0;
      ptr_q    <= '0;
      status_q <= ST_OK;
      grant_q  <= '0;
      rvalid_q <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef READER_TIMEOUT_EN
      cnt_q    <= '0;
      tcount_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      ptr_q    <= ptr_d;
      status_q <= status_d;
      grant_q  <= grant_d;
      rvalid_q <= rvalid_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
`ifdef READER_TIMEOUT_EN
      cnt_q    <= cnt_d;
      tcount_q <= tcount_d;
`endif
    end
  end

  assign lane_grant      = grant_q;
  assign lane_resp_valid = rvalid_q;
  assign resp_status     = status_q;
  assign rd_start        = start_q;
  assign rd_lane         = w_q;
  assign busy            = busy_q;
  assign dbg_state       = state_q;
`ifdef READER_TIMEOUT_EN
  assign timeout_count   = tcount_q;
`else
  assign timeout_count   = 8'd0;
`endif

endmodule

// File: tb/tb_toll_reader_arbiter.sv
// Directed bench for toll_reader_arbiter: per-cycle vector table for arbitration
// and status decode, plus hand sequences for timeout, maintenance, reset and stray strobes.
module tb_toll_reader_arbiter;
  import toll_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         maintenance_mode;
  logic [N-1:0] lane_req, lane_ack;
  logic [N-1:0] lane_grant, lane_resp_valid;
  logic [1:0]   resp_status;
  logic         rd_start;
  logic [1:0]   rd_lane;
  logic         rd_done, rd_present, rd_valid, rd_sufficient;
  logic         busy;
  logic [7:0]   timeout_count;
  state_e       dbg_state;

  always #5 clk = ~clk;

  toll_reader_arbiter #(
    .NUM_LANES      (N),
    .LANE_W         (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .maintenance_mode (maintenance_mode),
    .lane_req         (lane_req),
    .lane_ack         (lane_ack),
    .lane_grant       (lane_grant),
    .lane_resp_valid  (lane_resp_valid),
    .resp_status      (resp_status),
    .rd_start         (rd_start),
    .rd_lane          (rd_lane),
    .rd_done          (rd_done),
    .rd_present       (rd_present),
    .rd_valid         (rd_valid),
    .rd_sufficient    (rd_sufficient),
    .busy             (busy),
    .timeout_count    (timeout_count),
    .dbg_state        (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] ack;
    logic       done, pres, val, suf;
    logic [3:0] e_grant, e_valid;
    logic [1:0] e_status;
    logic       e_start;
    logic [1:0] e_lane;
    logic       e_busy;
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] last_status = ST_OK;

  function automatic void push(input logic [3:0] req, input logic [3:0] ack,
                               input logic done, input logic p, input logic v, input logic s,
                               input logic [3:0] eg, input logic [3:0] ev, input logic [1:0] es,
                               input logic estart, input logic [1:0] elane, input logic ebusy);
    vec_t r;
    r.req = req; r.ack = ack; r.done = done; r.pres = p; r.val = v; r.suf = s;
    r.e_grant = eg; r.e_valid = ev; r.e_status = es;
    r.e_start = estart; r.e_lane = elane; r.e_busy = ebusy;
    vecs.push_back(r);
  endfunction

  // One full transaction from IDLE: grant, two WAIT cycles, reader result,
  // `hold` RESP cycles without ack, then the ack cycle.
  function automatic void add_txn(input int lane, input logic [3:0] req,
                                  input logic p, input logic v, input logic s,
                                  input logic [1:0] st, input int hold);
    logic [3:0] oh;
    logic [1:0] ln;
    oh = 4'b0001 << lane;
    ln = 2'(lane);
    push(req, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, oh, 4'b0, last_status, 1'b1, ln, 1'b1);
    push(req, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, oh, 4'b0, last_status, 1'b0, ln, 1'b1);
    push(req, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, oh, 4'b0, last_status, 1'b0, ln, 1'b1);
    push(req, 4'b0, 1'b1, p, v, s, 4'b0, oh, st, 1'b0, ln, 1'b1);
    for (int h = 0; h < hold; h++) begin
      push(req, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, oh, st, 1'b0, ln, 1'b1);
    end
    push(req, oh, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0, st, 1'b0, ln, 1'b0);
    last_status = st;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] g, input logic [3:0] v,
                         input logic [1:0] st, input logic s, input logic [1:0] ln, input logic b);
    check({tag, " grant"},  32'(lane_grant),      32'(g));
    check({tag, " valid"},  32'(lane_resp_valid), 32'(v));
    check({tag, " status"}, 32'(resp_status),     32'(st));
    check({tag, " start"},  32'(rd_start),        32'(s));
    check({tag, " lane"},   32'(rd_lane),         32'(ln));
    check({tag, " busy"},   32'(busy),            32'(b));
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max; c++) begin
      tick();
      if (lane_resp_valid != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int misses;
    int stray_grants;

    reset = 1'b1; maintenance_mode = 1'b0;
    lane_req = '0; lane_ack = '0;
    rd_done = 1'b0; rd_present = 1'b0; rd_valid = 1'b0; rd_sufficient = 1'b0;

    // Two-lane round robin, then status decode with longer RESP holds.
    add_txn(0, 4'b0101, 1'b1, 1'b1, 1'b1, ST_OK, 1);
    add_txn(2, 4'b0101, 1'b1, 1'b1, 1'b1, ST_OK, 1);
    add_txn(0, 4'b0101, 1'b1, 1'b1, 1'b1, ST_OK, 1);
    add_txn(2, 4'b0101, 1'b1, 1'b1, 1'b1, ST_OK, 1);
    add_txn(0, 4'b0101, 1'b0, 1'b0, 1'b0, ST_NO_TAG, 3);
    add_txn(2, 4'b0101, 1'b1, 1'b1, 1'b0, ST_REJECT, 3);
    add_txn(0, 4'b0101, 1'b1, 1'b1, 1'b1, ST_OK, 3);

    #12;
    chk_out("reset", 4'b0, 4'b0, ST_OK, 1'b0, 2'd0, 1'b0);
    check("reset state", 32'(dbg_state), 32'(IDLE));
    check("reset tcount", 32'(timeout_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      lane_req = vecs[i].req; lane_ack = vecs[i].ack;
      rd_done = vecs[i].done; rd_present = vecs[i].pres;
      rd_valid = vecs[i].val; rd_sufficient = vecs[i].suf;
      tick();
      chk_out($sformatf("v%0d", i), vecs[i].e_grant, vecs[i].e_valid, vecs[i].e_status,
              vecs[i].e_start, vecs[i].e_lane, vecs[i].e_busy);
    end
    lane_req = '0; lane_ack = '0;
    rd_done = 1'b0; rd_present = 1'b0; rd_valid = 1'b0; rd_sufficient = 1'b0;
    tick();

`ifdef READER_TIMEOUT_EN
    // Timeout after 8 WAIT cycles (rr_ptr is 1, lane 1 alone requests).
    lane_req = 4'b0010;
    tick();
    chk_out("to grant", 4'b0010, 4'b0, ST_OK, 1'b1, 2'd1, 1'b1);
    tick();
    check("to wait entry", 32'(dbg_state), 32'(WAIT));
    repeat (7) tick();
    check("to still wait valid", 32'(lane_resp_valid), 32'd0);
    check("to still wait grant", 32'(lane_grant), 32'b0010);
    tick();
    check("to resp valid", 32'(lane_resp_valid), 32'b0010);
    check("to resp status", 32'(resp_status), 32'(ST_TIMEOUT));
    check("to count 1", 32'(timeout_count), 32'd1);
    lane_ack = 4'b0010; tick(); lane_ack = '0;
    check("to ack idle", 32'(busy), 32'd0);

    // rd_done on the terminal WAIT cycle beats the timeout.
    tick(); tick();
    repeat (7) tick();
    rd_done = 1'b1; rd_present = 1'b0;
    tick();
    rd_done = 1'b0;
    check("tie valid", 32'(lane_resp_valid), 32'b0010);
    check("tie status", 32'(resp_status), 32'(ST_NO_TAG));
    check("tie count", 32'(timeout_count), 32'd1);
    lane_ack = 4'b0010; tick(); lane_ack = '0;

    misses = 0;
    for (int k = 0; k < 299; k++) begin
      wait_valid(40, ok);
      if (!ok) begin
        misses++;
        break;
      end
      lane_ack = 4'b0010; tick(); lane_ack = '0;
    end
    check("to loop bound", 32'(misses), 32'd0);
    check("to saturate", 32'(timeout_count), 32'd255);
    check("to sat status", 32'(resp_status), 32'(ST_TIMEOUT));
    lane_req = '0;
    tick();
`else
    // Without the timeout build, WAIT waits indefinitely for the reader.
    lane_req = 4'b0010;
    tick(); tick();
    repeat (40) tick();
    check("nto wait state", 32'(dbg_state), 32'(WAIT));
    check("nto wait grant", 32'(lane_grant), 32'b0010);
    check("nto wait valid", 32'(lane_resp_valid), 32'd0);
    check("nto tcount", 32'(timeout_count), 32'd0);
    rd_done = 1'b1; rd_present = 1'b1; rd_valid = 1'b0; rd_sufficient = 1'b1;
    tick();
    rd_done = 1'b0;
    check("nto resp valid", 32'(lane_resp_valid), 32'b0010);
    check("nto resp status", 32'(resp_status), 32'(ST_REJECT));
    lane_ack = 4'b0010; tick(); lane_ack = '0;
    lane_req = '0;
    tick();
`endif

    // Maintenance mode raised mid-transaction, plus stray acks in RESP.
    reset = 1'b1; tick(); reset = 1'b0;
    lane_req = 4'b1111;
    tick();
    chk_out("mnt grant", 4'b0001, 4'b0, ST_OK, 1'b1, 2'd0, 1'b1);
    tick();
    maintenance_mode = 1'b1;
    tick();
    check("mnt wait state", 32'(dbg_state), 32'(WAIT));
    check("mnt wait grant", 32'(lane_grant), 32'b0001);
    rd_done = 1'b1; rd_present = 1'b0; rd_valid = 1'b0; rd_sufficient = 1'b0;
    tick();
    rd_done = 1'b0;
    check("mnt resp valid", 32'(lane_resp_valid), 32'b0001);
    check("mnt resp status", 32'(resp_status), 32'(ST_NO_TAG));
    lane_ack = 4'b1110;
    tick(); tick();
    check("stray ack state", 32'(dbg_state), 32'(RESP));
    check("stray ack valid", 32'(lane_resp_valid), 32'b0001);
    lane_ack = 4'b0001; tick(); lane_ack = '0;
    check("mnt ack busy", 32'(busy), 32'd0);
    stray_grants = 0;
    repeat (5) begin
      tick();
      if (lane_grant != '0 || busy) stray_grants++;
    end
    check("mnt no grant", 32'(stray_grants), 32'd0);
    maintenance_mode = 1'b0;
    tick();
    chk_out("mnt resume", 4'b0010, 4'b0, ST_NO_TAG, 1'b1, 2'd1, 1'b1);
    tick();
    check("mnt resume wait", 32'(dbg_state), 32'(WAIT));

    // Asynchronous reset mid-WAIT; rr_ptr (2 before reset) must restart at 0.
    #2;
    reset = 1'b1;
    #1;
    chk_out("async rst", 4'b0, 4'b0, ST_OK, 1'b0, 2'd0, 1'b0);
    check("async rst state", 32'(dbg_state), 32'(IDLE));
    check("async rst tcount", 32'(timeout_count), 32'd0);
    lane_req = 4'b0110;
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk_out("rst ptr0", 4'b0010, 4'b0, ST_OK, 1'b1, 2'd1, 1'b1);
    tick();
    reset = 1'b1;
    #1;
    check("rst2 busy", 32'(busy), 32'd0);
    lane_req = 4'b1000;
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk_out("rst lane3", 4'b1000, 4'b0, ST_OK, 1'b1, 2'd3, 1'b1);

    // rd_done outside WAIT (GRANT, RESP, IDLE) has no effect.
    rd_done = 1'b1; rd_present = 1'b0;
    tick();
    rd_done = 1'b0;
    check("late grant state", 32'(dbg_state), 32'(WAIT));
    chk_out("late grant", 4'b1000, 4'b0, ST_OK, 1'b0, 2'd3, 1'b1);
    rd_done = 1'b1; rd_present = 1'b1; rd_valid = 1'b0; rd_sufficient = 1'b1;
    tick();
    rd_done = 1'b0;
    chk_out("late real", 4'b0, 4'b1000, ST_REJECT, 1'b0, 2'd3, 1'b1);
    rd_done = 1'b1; rd_present = 1'b0;
    tick();
    rd_done = 1'b0;
    check("late resp state", 32'(dbg_state), 32'(RESP));
    chk_out("late resp", 4'b0, 4'b1000, ST_REJECT, 1'b0, 2'd3, 1'b1);
    lane_req = '0;
    lane_ack = 4'b1000; tick(); lane_ack = '0;
    rd_done = 1'b1; rd_present = 1'b1; rd_valid = 1'b1; rd_sufficient = 1'b1;
    tick();
    rd_done = 1'b0;
    check("late idle state", 32'(dbg_state), 32'(IDLE));
    chk_out("late idle", 4'b0, 4'b0, ST_REJECT, 1'b0, 2'd3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/toll_reader_arbiter.md
# toll_reader_arbiter

Shares a single RFID reader/validator among `NUM_LANES` toll booth lane controllers. Each lane requests a tag read when a vehicle arrives. The arbiter grants one lane at a time in round-robin order, sequences the reader, and returns a registered status to the granted lane over a valid/ack handshake. With the timeout feature compiled in, it also counts reader timeouts for the maintenance console.

## Interface
Parameters:
- `NUM_LANES`, 4: number of requesting lanes (2..8).
- `LANE_W`, 2: lane index width, equal to clog2(`NUM_LANES`).
- `TIMEOUT_CYCLES`, 1000: maximum cycles spent in WAIT before a timeout (requires `READER_TIMEOUT_EN`).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `maintenance_mode`  in  1  suppresses new grants.
- `lane_req`  in  `NUM_LANES`  per-lane read request, level.
- `lane_ack`  in  `NUM_LANES`  per-lane response acknowledge.
- `lane_grant`  out  `NUM_LANES`  one-hot grant, or all zero.
- `lane_resp_valid`  out  `NUM_LANES`  one-hot response valid.
- `resp_status`  out  2  response code: 00 OK, 01 NO_TAG, 10 REJECT, 11 TIMEOUT.
- `rd_start`  out  1  one-cycle pulse that starts the reader.
- `rd_lane`  out  `LANE_W`  index of the lane being served.
- `rd_done`  in  1  reader result strobe.
- `rd_present`, `rd_valid`, `rd_sufficient`  in  1 each  reader result fields, qualified by `rd_done`.
- `busy`  out  1  high in every state except IDLE.
- `timeout_count`  out  8  saturating count of reader timeouts.

## Operation
States:
- **IDLE**
  - If `maintenance_mode` is 0 and any bit of `lane_req` is set, pick the winner and go to GRANT.
  - The winner is the first requesting lane at or after `rr_ptr`, searching upward and wrapping.
- **GRANT**
  - `rd_start` is 1, `lane_grant[w]` is 1, `rd_lane` = w.
  - Set `rr_ptr` to (w+1) mod `NUM_LANES`.
  - Go to WAIT.
- **WAIT**
  - `lane_grant[w]` stays asserted.
  - On `rd_done`, latch the status and go to RESP.
  - Status latch rule: `!rd_present` gives NO_TAG; otherwise `rd_valid && rd_sufficient` gives OK; otherwise REJECT.
- **RESP**
  - `lane_resp_valid[w]` is 1 and `resp_status` is held stable.
  - On `lane_ack[w]`, go to IDLE.
  - `lane_ack` bits from any other lane are ignored.

Boundary rules:
- Dropping `lane_req` after the grant does not abort the transaction. The transaction runs to RESP and waits for ack.
- `rd_done` is honoured only in WAIT. It is ignored in IDLE, GRANT and RESP.
- A lane that holds `lane_req` through ack re-enters arbitration. Because `rr_ptr` has moved, the other requesting lanes are served first.
- `maintenance_mode` blocks only the IDLE to GRANT transition. A transaction already in flight completes normally.
- Reset values, including reset applied mid-transaction:
  - state IDLE, `rr_ptr` 0.
  - `lane_grant`, `lane_resp_valid`, `rd_start`, `busy` all 0.
  - `rd_lane` 0, `resp_status` 00, `timeout_count` 0.

## Timing
- All outputs are registered.
- Request to start: `lane_req` sampled at edge t gives `lane_grant` and `rd_start` in cycle t+1, and WAIT in cycle t+2.
- Result to response: `rd_done` sampled at edge d gives `lane_resp_valid` and `resp_status` in cycle d+1.
- Ack to next grant: `lane_ack` sampled at edge a gives IDLE in a+1. The grant drops in the same cycle. The earliest next grant is a+2.
- Minimum transaction length with `rd_done` in the first WAIT cycle: 4 cycles (GRANT, WAIT, RESP, IDLE).
- `rd_start` is high for exactly one cycle per grant.

## Configuration
`READER_TIMEOUT_EN` defined:
- A cycle counter clears on entry to WAIT and increments each WAIT cycle.
- After `TIMEOUT_CYCLES` WAIT cycles without `rd_done`, latch TIMEOUT, go to RESP, and increment `timeout_count`, saturating at 255.
- If `rd_done` arrives in the same cycle as the terminal count, `rd_done` wins.

`READER_TIMEOUT_EN` undefined:
- WAIT lasts until `rd_done`, with no limit.
- TIMEOUT is never produced.
- `timeout_count` is tied to 0 and no timeout counter is synthesized.

## Structure
- Package `toll_pkg` holds:
  - the state enum (IDLE, GRANT, WAIT, RESP);
  - the `resp_status` encoding constants (ST_OK, ST_NO_TAG, ST_REJECT, ST_TIMEOUT);
  - the default `NUM_LANES`.
- Sub-module `rr_pick`: a combinational round-robin priority picker. It takes the request vector and `rr_ptr` and returns a one-hot winner plus its index. It is reused wherever the codebase shares a resource between lanes.

## Test plan
1. **Two-lane round-robin.** From reset, `lane_req`=0b0101 held. Each lane acks 1 cycle after valid and the reader returns OK 2 cycles after start.
   - Grants go to lane 0, then 2, then 0, then 2.
   - `rd_lane` = 0, 2, 0, 2.
   - Status 00 each time.
2. **Status decode.** Give successive reads with `rd_present`=0, then `rd_present`=1 with `rd_valid`=1 and `rd_sufficient`=0, then all three 1.
   - Statuses are 01, 10, 00.
   - Each status holds stable until ack.
3. **Timeout** (macro on, `TIMEOUT_CYCLES`=8). Never assert `rd_done`.
   - RESP is reached 8 cycles after WAIT entry with status 11.
   - `timeout_count` = 1.
   - After 300 such timeouts, `timeout_count` reads 255.
4. **Maintenance and stray acks.** Set `maintenance_mode`=1 in WAIT with `lane_req`=0b1111.
   - The current transaction completes.
   - No new grant appears while the mode is high.
   - A grant resumes 1 cycle after the mode drops.
   - `lane_ack` from a non-granted lane does not leave RESP.
5. **Reset mid-transaction.** Assert `reset` during WAIT.
   - All outputs return to reset values asynchronously.
   - After release with `lane_req`=0b1000, lane 3 is granted with `rr_ptr` starting from 0.
6. **Late `rd_done`.** Pulse `rd_done` during GRANT and during RESP.
   - Both pulses are ignored: no state change and no status change.
